// File: rtl/eth_rmii_tx.sv
// RMII transmit framer: preamble/SFD, payload, optional zero-pad, FCS, then inter-frame gap.
// Build option: define ETH_TX_PAD_EN to zero-pad short frames up to pMin_Frame bytes before the FCS.
module eth_rmii_tx #(
    parameter int pMin_Frame  = 60,
    parameter int pIfg_Cycles = 48
) (
    input  logic       Eth_Clk,
    input  logic       Eth_Rst,
    input  logic [7:0] Tx_Byte,
    input  logic       Tx_Byte_Valid,
    input  logic       Tx_Byte_Last,
    output logic       Tx_Byte_Ready,
    output logic       Tx_Busy,
    output logic       Tx_Underrun,
    output logic [1:0] Txd,
    output logic       Tx_En
);

`ifdef ETH_TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    localparam logic [10:0] MinCnt  = 11'(pMin_Frame);
    localparam logic [7:0]  IfgLast = 8'(pIfg_Cycles - 2);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

    state_t      state_q, state_d;
    logic [1:0]  dc_q, dc_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_last_q, hold_last_d;
    logic        cur_last_q, cur_last_d;
    logic        abort_q, abort_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  txd_q, txd_d;
    logic        en_q, en_d, rdy_q, rdy_d, busy_q, busy_d, und_q, und_d;

    logic       xfer, miss, load, data_ld, pad_ld, fcs_ld;
    logic [7:0] nbyte, byte_sel;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        dc_d        = dc_q;
        bcnt_d      = bcnt_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        cur_last_d  = cur_last_q;
        abort_d     = abort_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        rdy_d       = 1'b0;
        und_d       = 1'b0;
        load        = 1'b0;
        data_ld     = 1'b0;
        pad_ld      = 1'b0;
        fcs_ld      = 1'b0;
        nbyte       = 8'h00;

        xfer = Tx_Byte_Valid & rdy_q;
        miss = rdy_q & ~Tx_Byte_Valid & (state_q != IDLE);
        if (xfer) begin
            hold_d      = Tx_Byte;
            hold_last_d = Tx_Byte_Last;
        end
        if (miss) begin
            und_d   = 1'b1;
            abort_d = 1'b1;
        end
        if (state_q != IDLE && state_q != IFG) dc_d = dc_q + 2'd1;

        unique case (state_q)
            IDLE: begin
                rdy_d = ~xfer;
                if (xfer) begin
                    state_d = PRE;
                    dc_d    = 2'd0;
                    bcnt_d  = 8'd0;
                    load    = 1'b1;
                    nbyte   = 8'h55;
                    crc_d   = '1;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end
            end
            PRE: if (dc_q == 2'd3) begin
                load = 1'b1;
                if (bcnt_q == 8'd6) begin
                    state_d = SFD;
                    nbyte   = 8'hD5;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                    nbyte  = 8'h55;
                end
            end
            SFD: if (dc_q == 2'd3) begin
                state_d = DATA;
                data_ld = 1'b1;
            end
            DATA: if (dc_q == 2'd3) begin
                if (!cur_last_q) data_ld = 1'b1;
                else if (abort_q) begin
                    state_d = IFG;
                    bcnt_d  = 8'd0;
                end else if (PadEn && cnt_q < MinCnt) begin
                    state_d = PAD;
                    pad_ld  = 1'b1;
                end else fcs_ld = 1'b1;
            end
            PAD: if (dc_q == 2'd3) begin
                if (cnt_q < MinCnt) pad_ld = 1'b1;
                else fcs_ld = 1'b1;
            end
            FCS: if (dc_q == 2'd3) begin
                if (bcnt_q == 8'd3) begin
                    state_d = IFG;
                    bcnt_d  = 8'd0;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                    load   = 1'b1;
                    nbyte  = ~crc_q[7:0];
                    crc_d  = crc_q >> 8;
                end
            end
            IFG: begin
                // The IDLE cycle that follows is the last gap clock, so back-to-back frames see exactly pIfg_Cycles.
                if (bcnt_q == IfgLast) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else bcnt_d = bcnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // A byte missing at fetch time makes the byte now being loaded the final one.
        if (data_ld) begin
            load       = 1'b1;
            nbyte      = hold_q;
            cur_last_d = hold_last_q | miss;
            crc_d      = crc_byte(crc_q, hold_q);
            cnt_d      = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
        end
        if (pad_ld) begin
            load  = 1'b1;
            nbyte = 8'h00;
            crc_d = crc_byte(crc_q, 8'h00);
            cnt_d = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
        end
        if (fcs_ld) begin
            state_d = FCS;
            bcnt_d  = 8'd0;
            load    = 1'b1;
            nbyte   = ~crc_q[7:0];
            crc_d   = crc_q >> 8;
        end

        byte_sel = load ? nbyte : sh_q;
        sh_d     = byte_sel;
        en_d     = state_d inside {PRE, SFD, DATA, PAD, FCS};
        txd_d    = en_d ? byte_sel[{dc_d, 1'b0} +: 2] : 2'b00;
        busy_d   = (state_d != IDLE);
        if ((state_d == SFD || state_d == DATA) && dc_d == 2'd3 && !hold_last_q && !abort_d)
            rdy_d = 1'b1;
    end

    always_ff @(posedge Eth_Clk or posedge Eth_Rst) begin
        if (Eth_Rst) begin
            state_q     <= IDLE;
            dc_q        <= '0;
            bcnt_q      <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            cur_last_q  <= 1'b0;
            abort_q     <= 1'b0;
            crc_q       <= '1;
            cnt_q       <= '0;
            txd_q       <= '0;
            en_q        <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dc_q        <= dc_d;
            bcnt_q      <= bcnt_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            cur_last_q  <= cur_last_d;
            abort_q     <= abort_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            txd_q       <= txd_d;
            en_q        <= en_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
            und_q       <= und_d;
        end
    end

    assign Txd           = txd_q;
    assign Tx_En         = en_q;
    assign Tx_Byte_Ready = rdy_q;
    assign Tx_Busy       = busy_q;
    assign Tx_Underrun   = und_q;

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Bench for eth_rmii_tx: wire bytes scoreboarded against a software framer, frame timing from a table.
module tb_eth_rmii_tx;
    logic       Eth_Clk = 1'b0;
    logic       Eth_Rst = 1'b1;
    logic [7:0] Tx_Byte = 8'h00;
    logic       Tx_Byte_Valid = 1'b0;
    logic       Tx_Byte_Last = 1'b0;
    logic       Tx_Byte_Ready, Tx_Busy, Tx_Underrun, Tx_En;
    logic [1:0] Txd;

`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    eth_rmii_tx dut (
        .Eth_Clk(Eth_Clk), .Eth_Rst(Eth_Rst), .Tx_Byte(Tx_Byte), .Tx_Byte_Valid(Tx_Byte_Valid),
        .Tx_Byte_Last(Tx_Byte_Last), .Tx_Byte_Ready(Tx_Byte_Ready), .Tx_Busy(Tx_Busy),
        .Tx_Underrun(Tx_Underrun), .Txd(Txd), .Tx_En(Tx_En)
    );

    always #10 Eth_Clk = ~Eth_Clk;

    int checks = 0, passed = 0;
    logic [7:0] exp_q[$];
    int en_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] pbyte(input int pat, input int i);
        case (pat)
            0:       return 8'(8'h31 + i);
            1:       return 8'(i * 7 + 3);
            2:       return 8'(i) ^ 8'hA5;
            3:       return 8'(8'hF0 - i);
            default: return 8'(i * 13);
        endcase
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic void push_frame(input int len, input int pat, input int drop_at);
        logic [31:0] c, f;
        int n, tot;
        c = '1;
        n = (drop_at > 0) ? drop_at - 1 : len;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pbyte(pat, i));
            c = crc_upd(c, pbyte(pat, i));
        end
        if (drop_at > 0) return;
        tot = n;
        while (PAD && tot < 60) begin
            exp_q.push_back(8'h00);
            c = crc_upd(c, 8'h00);
            tot++;
        end
        f = ~c;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(f[7:0]);
            f = f >> 8;
        end
    endfunction

    // Wire monitor: assembles dibits into bytes and measures frame timing.
    int nd = 0, en_len = 0, gap = 0, last_gap = -1, low_cnt = 0, rdy_delay = -1;
    int rdy_pulses = 0, und_cnt = 0, idle_txd_err = 0, rdy_space_err = 0, cyc = 0, last_rdy_cyc = -1;
    bit prev_en = 1'b0, want_rdy = 1'b0;
    logic [7:0] asm_b = 8'h00;

    always @(negedge Eth_Clk) begin
        cyc++;
        if (Eth_Rst) begin
            nd = 0; en_len = 0; prev_en = 1'b0; want_rdy = 1'b0; last_rdy_cyc = -1;
        end else begin
            if (!Tx_En && Txd != 2'b00) idle_txd_err++;
            if (Tx_Underrun) und_cnt++;
            if (!prev_en && Tx_En) begin
                last_gap = gap;
                last_rdy_cyc = -1;
            end
            if (Tx_Byte_Ready && Tx_En) begin
                rdy_pulses++;
                if (last_rdy_cyc >= 0 && cyc - last_rdy_cyc != 4) rdy_space_err++;
                last_rdy_cyc = cyc;
            end
            if (Tx_En) begin
                en_len++;
                asm_b = {Txd, asm_b[7:2]};
                nd++;
                if (nd == 4) begin
                    nd = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL wire_byte: got 0x%02h with no byte expected", asm_b);
                    end else chk("wire_byte", asm_b, exp_q.pop_front());
                end
            end else begin
                if (prev_en) begin
                    en_q.push_back(en_len);
                    chk("dibit_align", nd, 0);
                    en_len = 0; gap = 0; nd = 0; low_cnt = 0; want_rdy = 1'b1;
                end
                gap++;
                if (want_rdy) begin
                    low_cnt++;
                    if (Tx_Byte_Ready) begin
                        rdy_delay = low_cnt;
                        want_rdy = 1'b0;
                    end
                end
            end
            prev_en = Tx_En;
        end
    end

    task automatic send_frame(input int len, input int pat, input int drop_at, input int rst_at, input bit keep);
        int n;
        for (int i = 0; i < len; i++) begin
            @(negedge Eth_Clk);
            if (i + 1 == rst_at) begin
                chk("rst_pre_en", Tx_En, 1);
                Eth_Rst = 1'b1;
                #1;
                chk("rst_mid_en", Tx_En, 0);
                chk("rst_mid_txd", Txd, 0);
                chk("rst_mid_ready", Tx_Byte_Ready, 0);
                exp_q.delete();
                Tx_Byte_Valid = 1'b0;
                Tx_Byte_Last = 1'b0;
                repeat (3) @(negedge Eth_Clk);
                Eth_Rst = 1'b0;
                return;
            end
            Tx_Byte_Valid = (i + 1 != drop_at);
            Tx_Byte = pbyte(pat, i);
            Tx_Byte_Last = (i == len - 1);
            n = 0;
            while (!Tx_Byte_Ready && n < 3000) begin
                @(negedge Eth_Clk);
                n++;
            end
            if (!Tx_Byte_Ready) begin
                checks++;
                $display("FAIL ready_timeout: byte %0d never offered Ready", i);
                Tx_Byte_Valid = 1'b0;
                return;
            end
            @(posedge Eth_Clk);
            if (i + 1 == drop_at) return;
        end
        if (!keep) begin
            @(negedge Eth_Clk);
            Tx_Byte_Valid = 1'b0;
            Tx_Byte_Last = 1'b0;
        end
    endtask

    task automatic start_frame();
        @(negedge Eth_Clk);
        en_q.delete();
        exp_q.delete();
        rdy_pulses = 0; und_cnt = 0; rdy_space_err = 0; rdy_delay = -1;
    endtask

    task automatic frame_checks(input int exp_en, input int exp_rdy, input int exp_und);
        int n;
        n = 0;
        while (en_q.size() == 0 && n < 4000) begin
            @(negedge Eth_Clk);
            n++;
        end
        if (en_q.size() == 0) begin
            checks++;
            $display("FAIL frame_end_timeout: Tx_En never fell");
            return;
        end
        chk("tx_en_len", en_q.pop_front(), exp_en);
        chk("busy_in_ifg", Tx_Busy, 1);
        n = 0;
        while (want_rdy && n < 200) begin
            @(negedge Eth_Clk);
            n++;
        end
        @(negedge Eth_Clk);
        chk("ifg_ready_delay", rdy_delay, 48);
        chk("busy_idle", Tx_Busy, 0);
        chk("bytes_left", exp_q.size(), 0);
        chk("ready_pulses", rdy_pulses, exp_rdy);
        chk("underruns", und_cnt, exp_und);
        chk("ready_spacing", rdy_space_err, 0);
    endtask

    typedef struct {
        int len; int pat; int drop; int en; int rdy; int und;
    } vec_t;
    vec_t vt[5];

    initial begin
        vt[0] = '{9, 0, 0, PAD ? 288 : 84, 8, 0};
        vt[1] = '{10, 1, 0, PAD ? 288 : 88, 9, 0};
        vt[2] = '{64, 2, 0, 304, 63, 0};
        vt[3] = '{64, 2, 20, 108, 19, 1};
        vt[4] = '{1, 3, 0, PAD ? 288 : 52, 0, 0};

        // Reset behaviour
        #5;
        chk("por_en", Tx_En, 0);
        chk("por_ready", Tx_Byte_Ready, 0);
        @(negedge Eth_Clk);
        Eth_Rst = 1'b0;
        repeat (5) @(negedge Eth_Clk);
        chk("idle_ready", Tx_Byte_Ready, 1);
        Eth_Rst = 1'b1;
        #1;
        chk("rst_ready", Tx_Byte_Ready, 0);
        chk("rst_en", Tx_En, 0);
        chk("rst_txd", Txd, 0);
        chk("rst_busy", Tx_Busy, 0);
        repeat (2) @(negedge Eth_Clk);
        Eth_Rst = 1'b0;
        #1;
        chk("release_ready", Tx_Byte_Ready, 0);
        @(posedge Eth_Clk);
        #1;
        chk("first_edge_ready", Tx_Byte_Ready, 1);

        // "123456789" with the well-known check value on the wire
        start_frame();
        if (PAD) push_frame(9, 0, 0);
        else begin
            repeat (7) exp_q.push_back(8'h55);
            exp_q.push_back(8'hD5);
            for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
            exp_q.push_back(8'h26); exp_q.push_back(8'h39);
            exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        end
        send_frame(9, 0, 0, 0, 1'b0);
        frame_checks(PAD ? 288 : 84, 8, 0);

        for (int v = 0; v < 5; v++) begin
            start_frame();
            push_frame(vt[v].len, vt[v].pat, vt[v].drop);
            send_frame(vt[v].len, vt[v].pat, vt[v].drop, 0, 1'b0);
            frame_checks(vt[v].en, vt[v].rdy, vt[v].und);
        end

        // Back-to-back frames with Valid held, second one cut by reset
        start_frame();
        push_frame(12, 3, 0);
        push_frame(20, 4, 0);
        send_frame(12, 3, 0, 0, 1'b1);
        send_frame(20, 4, 0, 5, 1'b0);
        chk("b2b_gap", last_gap, 48);
        chk("b2b_first_len", (en_q.size() > 0) ? en_q.pop_front() : -1, PAD ? 288 : 96);
        start_frame();
        push_frame(9, 0, 0);
        send_frame(9, 0, 0, 0, 1'b0);
        frame_checks(PAD ? 288 : 84, 8, 0);

        chk("txd_zero_when_idle", idle_txd_err, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
